// File: rtl/voice_mix_normalizer_pkg.sv
// voice_mix_normalizer_pkg
//   Shared constants for the voice mixer: fixed-point format, sample-word
//   width, unity-volume shift, reciprocal precision, the default voice count
//   and the reciprocal helper used to build the normalisation ROM.
//   Also provides the REAL_TO_FIXED_POINT / FIXED_POINT_TO_SAMPLE_WIDTH
//   conversion macros.

`ifndef VOICE_MIX_NORMALIZER_PKG_SV
`define VOICE_MIX_NORMALIZER_PKG_SV

// Real value -> fixed-point integer (FIXED_POINT = 8 fractional bits).
`define REAL_TO_FIXED_POINT(x) ($rtoi((x) * 256.0))
// Fixed-point sample -> integer part (floor).
`define FIXED_POINT_TO_SAMPLE_WIDTH(x) ((x) >>> 8)

package voice_mix_normalizer_pkg;

  localparam int FIXED_POINT   = 8;
  localparam int WIDTH_DEFAULT = 24;
  localparam int SAMPLE_W      = WIDTH_DEFAULT + FIXED_POINT;
  localparam int OUT_W         = 32;

  // 1024 = unity gain, so the volume product is shifted right by 10.
  localparam int VOL_SHIFT     = 10;
  // Normalisation multiplies by round(2^24 / k) then shifts right by 24.
  localparam int RECIP_SHIFT   = 24;
  localparam int RECIP_W       = RECIP_SHIFT + 1;

  localparam int N_OSCILLATORS = 16;

  // round(2^RECIP_SHIFT / k); k = 0 has no meaning and yields 0.
  function automatic logic [RECIP_W-1:0] recip_value(input int k);
    if (k <= 0) return '0;
    return RECIP_W'(((1 << RECIP_SHIFT) + k / 2) / k);
  endfunction

endpackage

`endif

// File: rtl/voice_mix_normalizer_recip_rom.sv
// recip_rom
//   Combinational reciprocal table: k -> round(2^24 / k) for k = 1..N_WAVEGENS.
//   Out-of-range k (0 or > N_WAVEGENS) returns 0; the mixer never presents
//   such a value because the count is clamped upstream.
// Ports:
//   k      in   CNT_W   clamped voice count
//   recip  out  25      unsigned reciprocal, 2^24 = 1.0

module recip_rom
  import voice_mix_normalizer_pkg::*;
#(
  parameter int N_WAVEGENS = N_OSCILLATORS,
  parameter int CNT_W      = $clog2(N_WAVEGENS + 1)
) (
  input  logic [CNT_W-1:0]   k,
  output logic [RECIP_W-1:0] recip
);

  // NOTE: the output gets a default before the loop so no path through the
  // block leaves it unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    recip = '0;
    for (int i = 1; i <= N_WAVEGENS; i++) begin
      if (k == i[CNT_W-1:0]) recip = recip_value(i);
    end
  end

endmodule

// File: rtl/voice_mix_normalizer.sv
// voice_mix_normalizer
//   Mixes N_WAVEGENS oscillator samples into one master sample:
//     stage 1: S = sum(waves), count clamped to K in [1, N_WAVEGENS]
//     stage 2: V = (S * master_volume) >>> 10
//     stage 3: R = (V * round(2^24/K) + 2^23) >>> 24, then out
//   Fixed 3-cycle latency, one sample per clk, no handshake.
//   Build option MIXER_SATURATE_EN: when defined, R is saturated to the
//   32-bit signed range; otherwise out is the low 32 bits of R (wraps).
// Ports:
//   clk            in   1                       sample-rate clock
//   rst            in   1                       async active-high reset
//   waves          in   N_WAVEGENS x SW signed  per-voice samples (Q.8)
//   master_volume  in   16 unsigned             gain, 1024 = unity
//   num_enabled    in   32 signed               active voice count
//   out            out  32 signed               mixed sample (Q.8)

module voice_mix_normalizer
  import voice_mix_normalizer_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int N_WAVEGENS = N_OSCILLATORS
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic signed [WIDTH+FIXED_POINT-1:0]   waves [N_WAVEGENS],
  input  logic        [15:0]                    master_volume,
  input  logic signed [31:0]                    num_enabled,
  output logic signed [OUT_W-1:0]               out
);

  localparam int SW     = WIDTH + FIXED_POINT;
  localparam int CNT_W  = $clog2(N_WAVEGENS + 1);
  // One guard bit beyond log2(N) keeps the sum from ever overflowing.
  localparam int SUM_W  = SW + $clog2(N_WAVEGENS) + 1;
  localparam int VOL_W  = 17;  // 16-bit unsigned volume as a signed operand
  localparam int PROD_W = SUM_W + VOL_W;
  localparam int V_W    = PROD_W - VOL_SHIFT;
  localparam int P3_W   = V_W + RECIP_W + 1;
  localparam int R_W    = P3_W - RECIP_SHIFT;

  localparam logic signed [P3_W-1:0] ROUND_HALF = P3_W'(1) << (RECIP_SHIFT - 1);

  // ---------------- stage 1: sum + count clamp ----------------
  logic signed [SUM_W-1:0] sum_c;
  logic        [CNT_W-1:0] k_c;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < N_WAVEGENS; i++) begin
      sum_c = sum_c + {{(SUM_W - SW){waves[i][SW-1]}}, waves[i]};
    end
  end

  always_comb begin
    if (num_enabled <= 0)               k_c = CNT_W'(1);
    else if (num_enabled > N_WAVEGENS)  k_c = CNT_W'(N_WAVEGENS);
    else                                k_c = CNT_W'(num_enabled);
  end

  logic signed [SUM_W-1:0] sum_q;
  logic        [15:0]      vol_q;
  logic        [CNT_W-1:0] k1_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours; blocking here would let
  // one stage race through into the next within a single clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      vol_q <= '0;
      k1_q  <= '0;
    end else begin
      sum_q <= sum_c;
      vol_q <= master_volume;
      k1_q  <= k_c;
    end
  end

  // ---------------- stage 2: master volume ----------------
  logic signed [PROD_W-1:0] prod_c;
  logic signed [V_W-1:0]    v_c;

  assign prod_c = sum_q * $signed({1'b0, vol_q});
  // Arithmetic shift floors toward minus infinity.
  assign v_c    = V_W'(prod_c >>> VOL_SHIFT);

  logic signed [V_W-1:0]   v_q;
  logic        [CNT_W-1:0] k2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q  <= '0;
      k2_q <= '0;
    end else begin
      v_q  <= v_c;
      k2_q <= k1_q;
    end
  end

  // ---------------- stage 3: normalise ----------------
  logic [RECIP_W-1:0] recip;

  recip_rom #(
    .N_WAVEGENS (N_WAVEGENS),
    .CNT_W      (CNT_W)
  ) u_recip_rom (
    .k     (k2_q),
    .recip (recip)
  );

  logic signed [P3_W-1:0]  p3_c;
  logic signed [R_W-1:0]   r_c;
  logic signed [OUT_W-1:0] out_c;

  assign p3_c = v_q * $signed({1'b0, recip});
  assign r_c  = R_W'((p3_c + ROUND_HALF) >>> RECIP_SHIFT);

`ifdef MIXER_SATURATE_EN
  localparam logic signed [R_W-1:0] OUT_MAX = R_W'(32'sh7FFF_FFFF);
  localparam logic signed [R_W-1:0] OUT_MIN = ~OUT_MAX;

  always_comb begin
    if (r_c > OUT_MAX)       out_c = OUT_MAX[OUT_W-1:0];
    else if (r_c < OUT_MIN)  out_c = OUT_MIN[OUT_W-1:0];
    else                     out_c = OUT_W'(r_c);
  end
`else
  // Two's-complement wrap: keep the low 32 bits of R.
  assign out_c = OUT_W'(r_c);
`endif

  // Reset clears the output register along with the pipeline, so nothing
  // in flight at reset time ever reaches out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= '0;
    else     out <= out_c;
  end

endmodule

// File: tb/tb_voice_mix_normalizer.sv
// tb_voice_mix_normalizer
//   Self-checking bench for voice_mix_normalizer (N_WAVEGENS = 16, WIDTH = 24).
//   Table of directed vectors, a hand-written reset sequence, and a random
//   stream compared against an arithmetic reference model.

module tb_voice_mix_normalizer;

  localparam int N = 16;
`ifdef MIXER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic signed [31:0] waves [N];
  logic        [15:0] master_volume;
  logic signed [31:0] num_enabled;
  logic signed [31:0] out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  voice_mix_normalizer #(
    .WIDTH      (24),
    .N_WAVEGENS (N)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .waves         (waves),
    .master_volume (master_volume),
    .num_enabled   (num_enabled),
    .out           (out)
  );

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain wide-integer arithmetic straight from the mixing rules.
  function automatic logic signed [31:0] model(input logic signed [31:0] w [N],
                                               input logic [15:0] vol,
                                               input int ne);
    logic signed [127:0] s, v, r, volw, rcp;
    int k;
    s = 0;
    for (int i = 0; i < N; i++) s = s + w[i];
    k    = (ne <= 0) ? 1 : (ne > N) ? N : ne;
    volw = {112'd0, vol};
    v    = (s * volw) >>> 10;
    rcp  = ((128'sd1 <<< 24) + k / 2) / k;
    r    = (v * rcp + (128'sd1 <<< 23)) >>> 24;
    if (SAT) begin
      if (r > 128'sd2147483647)  r = 128'sd2147483647;
      if (r < -128'sd2147483648) r = -128'sd2147483648;
    end
    return r[31:0];
  endfunction

  typedef struct {
    string              name;
    logic signed [31:0] w0, w1, w2, wrest;
    logic        [15:0] vol;
    int                 ne;
    logic signed [31:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic drive(input logic signed [31:0] w0, w1, w2, wrest,
                       input logic [15:0] vol, input int ne);
    waves[0] = w0;
    waves[1] = w1;
    waves[2] = w2;
    for (int i = 3; i < N; i++) waves[i] = wrest;
    master_volume = vol;
    num_enabled   = ne;
  endtask

  logic signed [31:0] exp_q [$];

  initial begin
    tbl[0] = '{"three_voices", 256000, 256000, 256000, 0, 16'd1024, 3, 256000};
    tbl[1] = '{"half_volume",  256000, 256000, 256000, 0, 16'd512,  3, 128000};
    tbl[2] = '{"rounding",     300, 0, 0, 0, 16'd1024, 3, 100};
    tbl[3] = '{"round_neg",    -300, 0, 0, 0, 16'd1024, 3, -100};
    tbl[4] = '{"clamp_zero",   768000, 0, 0, 0, 16'd1024, 0, 768000};
    tbl[5] = '{"clamp_neg",    768000, 0, 0, 0, 16'd1024, -5, 768000};
    tbl[6] = '{"clamp_high",   768000, 0, 0, 0, 16'd1024, 40, 48000};
    tbl[7] = '{"double_vol",   1000, 0, 0, 0, 16'd2048, 1, 2000};
    tbl[8] = '{"all_max", 32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF,
               32'sh7FFF_FFFF, 16'd1024, 1, SAT ? 32'sh7FFF_FFFF : -32'sd16};
    tbl[9] = '{"all_min", 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000,
               32'sh8000_0000, 16'd1024, 1, SAT ? 32'sh8000_0000 : 32'sd0};

    // ---- reset with nonzero inputs ----
    rst = 1'b1;
    drive(256000, 256000, 256000, 0, 16'd1024, 3);
    #1 check("reset_immediate", out, 0);
    repeat (3) @(negedge clk);
    check("reset_held", out, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_release_2clk", out, 0);
    @(negedge clk);
    check("reset_release_3clk", out, 256000);

    // ---- directed table ----
    foreach (tbl[i]) begin
      drive(tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].wrest, tbl[i].vol, tbl[i].ne);
      repeat (3) @(negedge clk);
      check(tbl[i].name, out, tbl[i].exp);
    end

    // ---- reset mid-operation clears in-flight samples ----
    drive(256000, 256000, 256000, 0, 16'd1024, 3);
    repeat (3) @(negedge clk);
    drive(1000, 0, 0, 0, 16'd1024, 1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("midreset_immediate", out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midreset_flushed", out, 0);
    repeat (2) @(negedge clk);
    check("midreset_recover", out, 1000);

    // ---- randomized stream, new sample every clock ----
    for (int c = 0; c < 300; c++) begin
      if (c >= 3) check($sformatf("random_%0d", c - 3), out, exp_q.pop_front());
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 3))
          0:       waves[i] = $urandom;
          1:       waves[i] = $urandom_range(0, 2) == 0 ? 32'sh7FFF_FFFF : 32'sh8000_0000;
          default: waves[i] = int'($urandom_range(0, 2000000)) - 1000000;
        endcase
      end
      master_volume = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2048));
      num_enabled   = int'($urandom_range(0, 24)) - 4;
      exp_q.push_back(model(waves, master_volume, num_enabled));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
